// File: rtl/rom_rr_arbiter_if.sv
// Requester/ROM-side signal bundle for rom_rr_arbiter.
// The arbiter connects through the slave modport; requesters and the ROM model use master.
interface rom_rr_arbiter_if #(
    parameter int NREQ = 4,
    parameter int AW   = 4,
    parameter int DW   = 4
);
    logic [NREQ-1:0]    req;
    logic [NREQ*AW-1:0] addr_in;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    rd_valid;
    logic [DW-1:0]      rd_data;
    logic               rom_en;
    logic [AW-1:0]      rom_addr;
    logic [DW-1:0]      rom_data;

    modport master (
        output req, addr_in, rom_data,
        input  gnt, rd_valid, rd_data, rom_en, rom_addr
    );

    modport slave (
        input  req, addr_in, rom_data,
        output gnt, rd_valid, rd_data, rom_en, rom_addr
    );
endinterface

// File: rtl/rom_rr_arbiter.sv
// Round-robin arbiter sharing one registered ROM port among NREQ requesters, with return routing.
// Define ROM_ARB_STATS_EN to add the per-requester 8-bit grant counters on port gnt_cnt.
module rom_rr_arbiter #(
    parameter int NREQ = 4,
    parameter int AW   = 4,
    parameter int DW   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    rom_rr_arbiter_if.slave      bus
`ifdef ROM_ARB_STATS_EN
    ,
    output logic [NREQ*8-1:0]    gnt_cnt
`endif
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]   ptr;
    logic [PW-1:0]   winner;
    logic [NREQ-1:0] win_oh;
    logic            any_req;
    logic [AW-1:0]   addr_arr [NREQ];

    logic            s1_vld;
    logic [PW-1:0]   s1_own;
    logic            s2_vld;
    logic [PW-1:0]   s2_own;
    logic [NREQ-1:0] s2_oh;

    assign any_req = |bus.req;

    // Scan from the requester after the last winner, wrapping, so priority rotates.
    always_comb begin
        logic          found;
        logic [PW-1:0] cand;
        found  = 1'b0;
        cand   = '0;
        winner = ptr;
        for (int i = 1; i <= NREQ; i++) begin
            cand = PW'((int'(ptr) + i) % NREQ);
            if (!found && bus.req[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        win_oh         = '0;
        win_oh[winner] = 1'b1;
        s2_oh          = '0;
        s2_oh[s2_own]  = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            addr_arr[i] = bus.addr_in[i*AW +: AW];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.gnt      <= '0;
            bus.rom_en   <= 1'b0;
            bus.rom_addr <= '0;
            ptr          <= PW'(NREQ - 1);
            s1_vld       <= 1'b0;
            s1_own       <= '0;
        end else if (any_req) begin
            bus.gnt      <= win_oh;
            bus.rom_en   <= 1'b1;
            bus.rom_addr <= addr_arr[winner];
            ptr          <= winner;
            s1_vld       <= 1'b1;
            s1_own       <= winner;
        end else begin
            bus.gnt      <= '0;
            bus.rom_en   <= 1'b0;
            s1_vld       <= 1'b0;
        end
    end

    // Owner tag follows the read through the ROM's one-cycle register, then steers the return.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_vld       <= 1'b0;
            s2_own       <= '0;
            bus.rd_valid <= '0;
            bus.rd_data  <= '0;
        end else begin
            s2_vld       <= s1_vld;
            s2_own       <= s1_own;
            bus.rd_valid <= s2_vld ? s2_oh : '0;
            if (s2_vld) begin
                bus.rd_data <= bus.rom_data;
            end
        end
    end

`ifdef ROM_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_cnt <= '0;
        end else if (any_req) begin
            for (int i = 0; i < NREQ; i++) begin
                if (win_oh[i]) begin
                    gnt_cnt[i*8 +: 8] <= gnt_cnt[i*8 +: 8] + 8'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_rom_rr_arbiter.sv
// Scenario bench for rom_rr_arbiter: expected returns queued at grant time, popped when due.
// With ROM_ARB_STATS_EN defined the grant counters are also exercised.
module tb_rom_rr_arbiter;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   cyc;

    typedef struct {
        int         due;
        logic [3:0] owner;
        logic [3:0] data;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    logic [3:0] rom_q;

    rom_rr_arbiter_if #(.NREQ(4), .AW(4), .DW(4)) bif ();

`ifdef ROM_ARB_STATS_EN
    logic [31:0] gnt_cnt;
`endif

    rom_rr_arbiter #(.NREQ(4), .AW(4), .DW(4)) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bif.slave)
`ifdef ROM_ARB_STATS_EN
        ,
        .gnt_cnt (gnt_cnt)
`endif
    );

    // Registered ROM model: word = address inverted.
    always @(posedge clk) begin
        if (bif.rom_en) rom_q <= bif.rom_addr ^ 4'hF;
    end
    assign bif.rom_data = rom_q;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // Return scoreboard: a due entry must appear exactly then; otherwise rd_valid must stay low.
    always @(negedge clk) begin
        if (rst_n) begin
            if (sb.size() > 0 && sb[0].due == cyc) begin
                mon_e = sb.pop_front();
                checks++;
                if (bif.rd_valid !== mon_e.owner || bif.rd_data !== mon_e.data) begin
                    errors++;
                    $display("[TB] FAIL return got valid=%b data=%h expected valid=%b data=%h at cyc %0d",
                             bif.rd_valid, bif.rd_data, mon_e.owner, mon_e.data, cyc);
                end
            end else begin
                checks++;
                if (bif.rd_valid !== 4'b0000) begin
                    errors++;
                    $display("[TB] FAIL spurious_rd_valid got %b expected 0000 at cyc %0d", bif.rd_valid, cyc);
                end
            end
        end
    end

    task automatic drive_cycle(input logic [3:0] r);
        bif.req = r;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        bif.req = 4'b0000;
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        bif.req     = 4'b0000;
        bif.addr_in = 16'h0000;
        repeat (2) @(negedge clk);
        checks++;
        if (bif.gnt !== 4'b0 || bif.rd_valid !== 4'b0 || bif.rd_data !== 4'h0 ||
            bif.rom_en !== 1'b0 || bif.rom_addr !== 4'h0) begin
            errors++;
            $display("[TB] FAIL reset_state got gnt=%b rdv=%b rdd=%h en=%b addr=%h expected all zero",
                     bif.gnt, bif.rd_valid, bif.rd_data, bif.rom_en, bif.rom_addr);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single_read();
        bif.addr_in = 16'h000A;
        drive_cycle(4'b0001);
        checks++;
        if (bif.gnt !== 4'b0001 || bif.rom_en !== 1'b1 || bif.rom_addr !== 4'hA) begin
            errors++;
            $display("[TB] FAIL single_grant got gnt=%b en=%b addr=%h expected 0001 1 a",
                     bif.gnt, bif.rom_en, bif.rom_addr);
        end
        sb.push_back('{due: cyc + 2, owner: 4'b0001, data: 4'h5});
        drive_cycle(4'b0000);
        checks++;
        if (bif.gnt !== 4'b0000 || bif.rom_en !== 1'b0 || bif.rom_addr !== 4'hA) begin
            errors++;
            $display("[TB] FAIL single_idle got gnt=%b en=%b addr=%h expected 0000 0 a",
                     bif.gnt, bif.rom_en, bif.rom_addr);
        end
        repeat (3) drive_cycle(4'b0000);
    endtask

    task automatic test_round_robin();
        logic [3:0] eg;
        do_reset();
        bif.addr_in = {4'h3, 4'h2, 4'h1, 4'h0};
        for (int k = 0; k < 8; k++) begin
            drive_cycle(4'b1111);
            eg = 4'b0001 << (k % 4);
            checks++;
            if (bif.gnt !== eg || bif.rom_addr !== 4'(k % 4)) begin
                errors++;
                $display("[TB] FAIL rr_grant%0d got gnt=%b addr=%h expected gnt=%b addr=%h",
                         k, bif.gnt, bif.rom_addr, eg, 4'(k % 4));
            end
            sb.push_back('{due: cyc + 2, owner: eg, data: 4'(k % 4) ^ 4'hF});
        end
        repeat (3) drive_cycle(4'b0000);
    endtask

    task automatic test_back_to_back();
        bif.addr_in = 16'h00D0;
        for (int k = 0; k < 4; k++) begin
            drive_cycle(4'b0010);
            checks++;
            if (bif.gnt !== 4'b0010 || bif.rom_addr !== 4'hD) begin
                errors++;
                $display("[TB] FAIL b2b_grant%0d got gnt=%b addr=%h expected 0010 d", k, bif.gnt, bif.rom_addr);
            end
            sb.push_back('{due: cyc + 2, owner: 4'b0010, data: 4'h2});
        end
        repeat (3) drive_cycle(4'b0000);
    endtask

    task automatic test_drop();
        logic [3:0] rseq [5];
        logic [3:0] gseq [5];
        logic [3:0] dseq [5];
        rseq = '{4'b0001, 4'b0101, 4'b0101, 4'b0101, 4'b0000};
        gseq = '{4'b0001, 4'b0100, 4'b0001, 4'b0100, 4'b0000};
        dseq = '{4'hB,    4'h9,    4'hB,    4'h9,    4'h0};
        do_reset();
        bif.addr_in = {4'h7, 4'h6, 4'h5, 4'h4};
        for (int k = 0; k < 5; k++) begin
            drive_cycle(rseq[k]);
            checks++;
            if (bif.gnt !== gseq[k]) begin
                errors++;
                $display("[TB] FAIL drop_step%0d got gnt=%b expected %b", k, bif.gnt, gseq[k]);
            end
            if (gseq[k] != 4'b0000) begin
                sb.push_back('{due: cyc + 2, owner: gseq[k], data: dseq[k]});
            end
        end
        repeat (3) drive_cycle(4'b0000);
    endtask

    task automatic test_reset_mid();
        bif.addr_in = {4'h3, 4'h2, 4'h1, 4'h0};
        drive_cycle(4'b1000);
        checks++;
        if (bif.gnt !== 4'b1000) begin
            errors++;
            $display("[TB] FAIL mid_pre_grant got gnt=%b expected 1000", bif.gnt);
        end
        sb.push_back('{due: cyc + 2, owner: 4'b1000, data: 4'hC});
        #2;
        rst_n   = 1'b0;
        bif.req = 4'b0000;
        sb.delete();
        #1;
        checks++;
        if (bif.gnt !== 4'b0 || bif.rd_valid !== 4'b0 || bif.rd_data !== 4'h0 ||
            bif.rom_en !== 1'b0 || bif.rom_addr !== 4'h0) begin
            errors++;
            $display("[TB] FAIL mid_async_clear got gnt=%b rdv=%b rdd=%h en=%b addr=%h expected all zero",
                     bif.gnt, bif.rd_valid, bif.rd_data, bif.rom_en, bif.rom_addr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive_cycle(4'b1010);
        checks++;
        if (bif.gnt !== 4'b0010 || bif.rom_addr !== 4'h1) begin
            errors++;
            $display("[TB] FAIL mid_first_grant got gnt=%b addr=%h expected 0010 1", bif.gnt, bif.rom_addr);
        end
        sb.push_back('{due: cyc + 2, owner: 4'b0010, data: 4'hE});
        repeat (4) drive_cycle(4'b0000);
    endtask

`ifdef ROM_ARB_STATS_EN
    task automatic test_stats();
        do_reset();
        checks++;
        if (gnt_cnt !== 32'h0) begin
            errors++;
            $display("[TB] FAIL stats_reset got %h expected 00000000", gnt_cnt);
        end
        bif.addr_in = {4'h3, 4'h2, 4'h1, 4'h0};
        for (int k = 0; k < 300; k++) begin
            drive_cycle(4'b1000);
            checks++;
            if (bif.gnt !== 4'b1000) begin
                errors++;
                $display("[TB] FAIL stats_grant%0d got gnt=%b expected 1000", k, bif.gnt);
            end
            sb.push_back('{due: cyc + 2, owner: 4'b1000, data: 4'hC});
        end
        repeat (3) drive_cycle(4'b0000);
        checks++;
        if (gnt_cnt[31:24] !== 8'd44 || gnt_cnt[23:0] !== 24'h0) begin
            errors++;
            $display("[TB] FAIL stats_count got %h expected 2c000000", gnt_cnt);
        end
    endtask
`endif

    initial begin
        checks      = 0;
        errors      = 0;
        cyc         = 0;
        rom_q       = 4'h0;
        bif.req     = 4'b0000;
        bif.addr_in = 16'h0000;
        test_reset();
        test_single_read();
        test_round_robin();
        test_back_to_back();
        test_drop();
        test_reset_mid();
`ifdef ROM_ARB_STATS_EN
        test_stats();
`endif
        repeat (2) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL missing_returns got %0d pending expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
